// File: rtl/moving_sum.sv
// Windowed running sum over STAGES samples, paired with an external delay line
// that supplies the outgoing sample, plus a registered upward-crossing detect.
module moving_sum #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int SIGNED = 0,
  parameter int SUM_W  = WIDTH + $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] din_dly,
  output logic             sr_srst,
  input  logic [SUM_W-1:0] thresh,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             det
);

  localparam int CNT_W = $clog2(STAGES + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [SUM_W-1:0]   sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               above_r;
  logic               det_r;
  logic               restart_s;
  logic               ge_s;
  logic               hit_s;

  function automatic logic [SUM_W-1:0] ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) begin
      ext = {{(SUM_W - WIDTH){v[WIDTH-1]}}, v};
    end else begin
      ext = {{(SUM_W - WIDTH){1'b0}}, v};
    end
  endfunction

  // The delay line must clear on the same edge as the accumulator.
  assign restart_s = ~srst_n | clear;
  assign sr_srst   = restart_s;

  // Threshold compare and crossing qualifier.
  always_comb begin
    ge_s = 1'b0;
    if (SIGNED != 0) begin
      ge_s = $signed(sum_r) >= $signed(thresh);
    end else begin
      ge_s = sum_r >= thresh;
    end
    hit_s = (state_r == RUN) && ge_s;
  end

  // Fill/run next-state logic.
  always_comb begin
    state_s = state_r;
    if (restart_s) begin
      state_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (cnt_r == CNT_W'(STAGES - 1)) begin
            state_s = RUN;
          end else begin
            state_s = FILL;
          end
        end
        RUN:     state_s = RUN;
        default: state_s = FILL;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator, fill counter and detect registers.
  always_ff @(posedge clk) begin
    if (!srst_n || clear) begin
      sum_r   <= {SUM_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      above_r <= 1'b0;
      det_r   <= 1'b0;
    end else begin
      sum_r   <= sum_r + ext(din) - ext(din_dly);
      if (cnt_r != CNT_W'(STAGES)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      above_r <= hit_s;
      det_r   <= hit_s && !above_r;
    end
  end

  assign sum       = sum_r;
  assign sum_valid = (state_r == RUN);
  assign det       = det_r;

endmodule

// File: tb/tb_moving_sum.sv
// Table-driven check of moving_sum (unsigned and signed instances) fed by a
// behavioural three-stage delay line.
module tb_moving_sum;

  localparam int W  = 16;
  localparam int ST = 3;
  localparam int SW = 18;

  logic          clk = 1'b0;
  logic          srst_n;
  logic          clear;
  logic [W-1:0]  din;
  logic [W-1:0]  din_dly;
  logic [SW-1:0] thresh;
  logic          sr_srst_u, sr_srst_s;
  logic [SW-1:0] sum_u, sum_s;
  logic          valid_u, valid_s;
  logic          det_u, det_s;
  logic [W-1:0]  dl [ST];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  moving_sum #(.WIDTH(W), .STAGES(ST), .SIGNED(0)) u_u (
    .clk(clk), .srst_n(srst_n), .clear(clear), .din(din), .din_dly(din_dly),
    .sr_srst(sr_srst_u), .thresh(thresh), .sum(sum_u), .sum_valid(valid_u), .det(det_u)
  );

  moving_sum #(.WIDTH(W), .STAGES(ST), .SIGNED(1)) u_s (
    .clk(clk), .srst_n(srst_n), .clear(clear), .din(din), .din_dly(din_dly),
    .sr_srst(sr_srst_s), .thresh(thresh), .sum(sum_s), .sum_valid(valid_s), .det(det_s)
  );

  // Paired delay line, reset by the DUT's sr_srst.
  always @(posedge clk) begin
    if (sr_srst_u) begin
      for (int i = 0; i < ST; i++) dl[i] <= '0;
    end else begin
      dl[0] <= din;
      for (int i = 1; i < ST; i++) dl[i] <= dl[i-1];
    end
  end
  assign din_dly = dl[ST-1];

  typedef struct {
    logic          rn;
    logic          cl;
    logic [W-1:0]  d;
    logic [SW-1:0] t;
    logic [SW-1:0] e_sum;
    logic          e_valid;
    logic          e_det;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, input logic cl, input logic [W-1:0] d,
                     input logic [SW-1:0] t, input logic [SW-1:0] es,
                     input logic ev, input logic ed);
    vec_t v;
    v.rn = rn; v.cl = cl; v.d = d; v.t = t;
    v.e_sum = es; v.e_valid = ev; v.e_det = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, check sr_srst before the edge, settle after it.
  task automatic step(input logic rn, input logic cl, input logic [W-1:0] d,
                      input logic [SW-1:0] t);
    srst_n = rn; clear = cl; din = d; thresh = t;
    #1;
    check("sr_srst", {31'd0, sr_srst_u}, {31'd0, ~rn | cl});
    @(posedge clk);
    #1;
  endtask

  localparam logic [SW-1:0] TMAX = 18'h3FFFF;
  localparam logic [SW-1:0] T20  = 18'd20;

  initial begin
    srst_n = 1'b0; clear = 1'b0; din = 16'd0; thresh = TMAX;
    @(posedge clk); #1;

    // reset, constant 5
    add(1'b0, 1'b0, 16'd5, TMAX, 18'd0,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, TMAX, 18'd5,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, TMAX, 18'd10, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, TMAX, 18'd15, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd5, TMAX, 18'd15, 1'b1, 1'b0);
    // clear then ramp
    add(1'b1, 1'b1, 16'd9, TMAX, 18'd0,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd1, TMAX, 18'd1,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd2, TMAX, 18'd3,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd3, TMAX, 18'd6,  1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd4, TMAX, 18'd9,  1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd5, TMAX, 18'd12, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd6, TMAX, 18'd15, 1'b1, 1'b0);
    // 7s, clear mid-run, refill
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd18, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd20, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd21, 1'b1, 1'b0);
    add(1'b1, 1'b1, 16'd7, TMAX, 18'd0,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd7,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd14, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd7, TMAX, 18'd21, 1'b1, 1'b0);
    // threshold 20 crossings
    add(1'b1, 1'b1, 16'd0, T20, 18'd0,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, T20, 18'd5,  1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, T20, 18'd10, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'd5, T20, 18'd15, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd5, T20, 18'd15, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd19, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd23, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd27, 1'b1, 1'b1);
    add(1'b1, 1'b0, 16'd0, T20, 18'd18, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd0, T20, 18'd9,  1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd0, T20, 18'd0,  1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd9,  1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd18, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd27, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd9, T20, 18'd27, 1'b1, 1'b1);
    add(1'b1, 1'b0, 16'd9, T20, 18'd27, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rn, vecs[i].cl, vecs[i].d, vecs[i].t);
      check($sformatf("sum[%0d]", i),   {14'd0, sum_u},   {14'd0, vecs[i].e_sum});
      check($sformatf("valid[%0d]", i), {31'd0, valid_u}, {31'd0, vecs[i].e_valid});
      check($sformatf("det[%0d]", i),   {31'd0, det_u},   {31'd0, vecs[i].e_det});
    end

    // srst_n mid-run: everything back to reset values on that edge, then refill
    step(1'b0, 1'b0, 16'd5, T20);
    check("rst_sum",   {14'd0, sum_u}, 32'd0);
    check("rst_valid", {31'd0, valid_u}, 32'd0);
    check("rst_det",   {31'd0, det_u}, 32'd0);
    check("rst_valid_s", {31'd0, valid_s}, 32'd0);
    step(1'b1, 1'b0, 16'd5, TMAX);
    check("refill1", {13'd0, valid_u, sum_u}, {13'd0, 1'b0, 18'd5});
    step(1'b1, 1'b0, 16'd5, TMAX);
    check("refill2", {13'd0, valid_u, sum_u}, {13'd0, 1'b0, 18'd10});
    step(1'b1, 1'b0, 16'd5, TMAX);
    check("refill3", {13'd0, valid_u, sum_u}, {13'd0, 1'b1, 18'd15});

    // signed instance: -1 x3, then 0x8000 x3
    step(1'b1, 1'b1, 16'd0, TMAX);
    step(1'b1, 1'b0, 16'hFFFF, TMAX);
    check("s_m1", {13'd0, valid_s, sum_s}, {13'd0, 1'b0, 18'h3FFFF});
    step(1'b1, 1'b0, 16'hFFFF, TMAX);
    check("s_m2", {13'd0, valid_s, sum_s}, {13'd0, 1'b0, 18'h3FFFE});
    step(1'b1, 1'b0, 16'hFFFF, TMAX);
    check("s_m3", {13'd0, valid_s, sum_s}, {13'd0, 1'b1, 18'h3FFFD});
    check("u_3ffff", {14'd0, sum_u}, {14'd0, 18'd196605});
    step(1'b1, 1'b0, 16'h8000, TMAX);
    check("s_a", {14'd0, sum_s}, {14'd0, 18'h37FFE});
    step(1'b1, 1'b0, 16'h8000, TMAX);
    check("s_b", {14'd0, sum_s}, {14'd0, 18'h2FFFF});
    step(1'b1, 1'b0, 16'h8000, TMAX);
    check("s_min", {14'd0, sum_s}, {14'd0, 18'h28000});
    check("u_8000", {14'd0, sum_u}, {14'd0, 18'h18000});
    check("sr_srst_s", {31'd0, sr_srst_s}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/moving_sum.md
# moving_sum

Windowed running-sum stage that sits directly downstream of the `shift_register` delay line. Each cycle it adds the newest sample and subtracts the sample leaving the window, taken from the delay line's `dout`. It also drives that delay line's `srst`, so the delay line and the accumulator clear on the same edge. Output feeds threshold/energy detection logic and carries a registered upward-crossing detect pulse.

## Interface
- `WIDTH`, 16, sample width in bits.
- `STAGES`, 3, window length in samples. Must equal the paired delay line's `STAGES`; legal range 2 or more.
- `SIGNED`, 0, 1 = samples and threshold are two's complement, 0 = unsigned.
- `SUM_W`, `WIDTH + $clog2(STAGES)`, sum width. Derived; do not override.
- `clk`  in  1  clock; all logic on its rising edge.
- `srst_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous window restart, active-high.
- `din`  in  WIDTH  newest sample, accepted every cycle.
- `din_dly`  in  WIDTH  delay-line `dout`, i.e. `din` from STAGES cycles earlier.
- `sr_srst`  out  STAGES-independent 1 bit  active-high reset for the paired delay line's `srst`.
- `thresh`  in  SUM_W  detect threshold, sampled every cycle.
- `sum`  out  SUM_W  registered window sum.
- `sum_valid`  out  1  high once the window holds STAGES real samples.
- `det`  out  1  one-cycle pulse on an upward threshold crossing.

## Operation
- Combinational `sr_srst = ~srst_n | clear`. This is the only combinational output.
- Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to SUM_W before the add and subtract.
- Accumulate every cycle, not in reset and not in clear: `sum <= sum + ext(din) - ext(din_dly)`.
- Overflow is impossible by construction: |sum| never exceeds STAGES × max|din|.
- Fill counter `cnt`, range 0..STAGES, saturating. Increments each non-reset, non-clear cycle while below STAGES.
- State machine, two states:
  - FILL (`cnt < STAGES`): `sum_valid = 0`.
  - RUN (`cnt == STAGES`): `sum_valid = 1`.
  - FILL→RUN on the edge where `cnt` reaches STAGES. RUN→FILL only on reset or clear.
- Detect logic:
  - Holds `above_q`, meaning the previous valid sum was ≥ `thresh` (signed compare when SIGNED=1).
  - `det <= sum_valid && (sum >= thresh) && !above_q`.
  - `above_q <= sum_valid && (sum >= thresh)`.
  - Consequence: the first valid cycle can fire `det` if `sum` is already at or above `thresh`. While `sum` stays at or above `thresh`, `det` does not repeat.
- Reset (`srst_n = 0`) or `clear = 1`, with identical effect at the edge:
  - `sum = 0`, `cnt = 0`, `sum_valid = 0`, `det = 0`, `above_q = 0`.
  - State goes to FILL.
  - `din` in that cycle is discarded.
  - The paired delay line is zeroed on the same edge through `sr_srst`, so `din_dly` reads 0 for the next STAGES cycles. This is what keeps the fill arithmetic exact.
- Clear takes priority over accumulate. Reset takes priority over clear.

## Timing
- Latency is one cycle from `din` to `sum`.
- After the edge that samples `din(t)`: `sum = din(t-STAGES+1) + … + din(t)`, valid once `cnt == STAGES`.
- First valid output: `sum_valid` rises on the STAGES-th rising edge after reset or clear is deasserted.
- `det` asserts one cycle after the `sum` it evaluates, so detect latency is two cycles from `din`.
- `clear` held for N cycles restarts fill from the first cycle it is low.
- Reset values: `sum = 0`, `sum_valid = 0`, `det = 0`. `sr_srst` is 1 while `srst_n = 0`.

## Test plan
Bench configuration: pair the block with the delay line, WIDTH=16 and STAGES=3 unless noted.
- Constant `din = 5`, SIGNED=0, from reset release -> `sum_valid` rises on the 3rd edge with `sum = 15`. The prior two edges show `sum = 5`, then 10, with `sum_valid = 0`.
- Ramp `din = 1,2,3,4,5,…` -> valid sums 6, 9, 12, 15, advancing by 3 per cycle.
- SIGNED=1, `din = 16'hFFFF` every cycle -> `sum = -3` (18'h3FFFD). Then `din = 16'h8000` ×3 -> `sum = -98304` with no wrap.
- Clear pulse mid-run with `din = 7` -> next edge `sum = 0` and `sum_valid = 0`. Delay line reads 0. `sum_valid` is back to 1 three edges after clear drops, with `sum = 21`.
- `thresh = 20`, `din = 5` ×4, then 9 ×3, then 0 ×3, then 9 ×3 -> exactly one `det` pulse on each rise to `sum ≥ 20`. None while it stays high, none while it falls.
- `srst_n` pulled low mid-run -> all outputs return to reset values on that edge and `sr_srst = 1`. Refill behaves as in the first scenario.
